// File: rtl/alu_decode.sv
// RV32I OP / OP-IMM / LUI decoder that feeds the ALU through a registered 2-entry skid buffer.
// Define ALU_DECODE_ILLEGAL_EN to enable illegal-encoding detection; otherwise out_illegal is tied to 0.
module alu_decode #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs1_val,
  input  logic [WIDTH-1:0] in_rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_op,
  output logic             out_alt,
  output logic [4:0]       out_rd,
  output logic             out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             alt;
    logic [4:0]       rd;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e   occ_q, occ_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   in_ready_q;
  entry_t dec;
  logic   acc, rel;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_shift;
  logic [WIDTH-1:0] imm_i, imm_sh, imm_u;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign imm_i    = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_sh   = WIDTH'(in_instr[24:20]);
  assign imm_u    = WIDTH'({in_instr[31:12], 12'b0});

  always_comb begin
    dec         = '0;
    dec.rd      = in_instr[11:7];
    dec.op      = funct3;
`ifdef ALU_DECODE_ILLEGAL_EN
    case (opcode)
      OPC_OP: begin
        dec.a       = in_rs1_val;
        dec.b       = in_rs2_val;
        dec.alt     = in_instr[30];
        dec.illegal = !((in_instr[31:25] == 7'b0000000) ||
                        ((in_instr[31:25] == 7'b0100000) &&
                         ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        dec.a = in_rs1_val;
        if (is_shift) begin
          dec.b       = imm_sh;
          dec.alt     = (funct3 == 3'b101) && in_instr[30];
          dec.illegal = !((in_instr[31:25] == 7'b0000000) ||
                          ((in_instr[31:25] == 7'b0100000) && (funct3 == 3'b101)));
        end else begin
          dec.b = imm_i;
        end
      end
      OPC_LUI: begin
        dec.b  = imm_u;
        dec.op = 3'b000;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries keep only rd so the slot still retires in order downstream.
    if (dec.illegal) begin
      dec.a   = '0;
      dec.b   = '0;
      dec.op  = 3'b000;
      dec.alt = 1'b0;
    end
`else
    case (opcode)
      OPC_OP: begin
        dec.a   = in_rs1_val;
        dec.b   = in_rs2_val;
        dec.alt = in_instr[30];
      end
      OPC_LUI: begin
        dec.b  = imm_u;
        dec.op = 3'b000;
      end
      default: begin
        // Unknown opcodes fall through to OP-IMM non-shift handling.
        dec.a = in_rs1_val;
        if ((opcode == OPC_OP_IMM) && is_shift) begin
          dec.b   = imm_sh;
          dec.alt = in_instr[30];
        end else begin
          dec.b = imm_i;
        end
      end
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != OCC_FULL);
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign acc = in_valid && in_ready_q;
  assign rel = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (acc) begin
          head_d = dec;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && rel) begin
          head_d = dec;
        end else if (acc) begin
          tail_d = dec;
          occ_d  = OCC_FULL;
        end else if (rel) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (rel) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_comb begin
    out_valid   = (occ_q != OCC_EMPTY);
    in_ready    = in_ready_q;
    out_a       = head_q.a;
    out_b       = head_q.b;
    out_op      = head_q.op;
    out_alt     = head_q.alt;
    out_rd      = head_q.rd;
    out_illegal = head_q.illegal;
  end

endmodule
